// File: rtl/cheri_clear_seq.sv
// Purpose : sequences CHERI capability-register clears onto a shared regfile write port,
//           one 8-register quarter per cycle, while normal writeback keeps absolute priority.
// Latency : accept in cycle 0, N non-empty quarters issue in cycles 1..N, done_o in N+1,
//           req_ready_o again in N+2; commit passthrough is combinational (zero latency).
// Backpressure: req_ready_o is high only in IDLE without flush_i; commit writes stall
//           clearing for that cycle and retire matching pending bits (the newer write wins).
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   req_valid_i/req_ready_o        clear request handshake, req_mask_i bit i = clear reg i
//   flush_i                        abandons an in-progress sequence (no done_o)
//   commit_we_i/_waddr_i/_wdata_i  normal writeback for the same regfile port
//   we_o, waddr_o, wdata_o         regfile write port
//   clr_o, mask_o, quarter_o       bulk-clear qualifier: clear the mask_o bits of quarter_o
//   busy_o, done_o                 sequence in progress / one-cycle completion pulse
module cheri_clear_seq #(
    parameter int DATA_WIDTH = 32,
    parameter bit SKIP_EMPTY = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [31:0]           req_mask_i,
    input  logic                  flush_i,
    input  logic                  commit_we_i,
    input  logic [4:0]            commit_waddr_i,
    input  logic [DATA_WIDTH-1:0] commit_wdata_i,
    output logic                  we_o,
    output logic [4:0]            waddr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  clr_o,
    output logic [7:0]            mask_o,
    output logic [1:0]            quarter_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pending_q;
    logic [1:0]  qcnt_q;

    logic [3:0]  byte_nz;
    logic [1:0]  first_q;
    logic [1:0]  sel_q;
    logic [7:0]  sel_byte;
    logic [2:0]  lsb_idx;
    logic        issue;
    logic        accept;
    logic [31:0] commit_hit;
    logic [31:0] issue_bits;
    logic [31:0] load_val;
    logic [31:0] run_next;

    assign byte_nz[0] = |pending_q[7:0];
    assign byte_nz[1] = |pending_q[15:8];
    assign byte_nz[2] = |pending_q[23:16];
    assign byte_nz[3] = |pending_q[31:24];

    // Lowest non-empty quarter; scanning downwards lets the lowest hit win.
    always_comb begin
        first_q = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (byte_nz[i]) first_q = 2'(i);
        end
    end

    assign sel_q    = SKIP_EMPTY ? first_q : qcnt_q;
    assign sel_byte = pending_q[{sel_q, 3'b000} +: 8];

    // waddr_o names the lowest register being cleared in the selected quarter.
    always_comb begin
        lsb_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (sel_byte[i]) lsb_idx = 3'(i);
        end
    end

    assign req_ready_o = (state_q == IDLE) && !flush_i;
    assign accept      = req_valid_i && req_ready_o;

    // Reset is sampled at the edge, but gating on it here keeps a clear from
    // appearing on the port in the cycle the sequence is being abandoned.
    assign issue = (state_q == RUN) && !commit_we_i && !flush_i && !rst_i && (sel_byte != 8'd0);

    // A commit to a register still pending makes its clear obsolete.
    assign commit_hit = commit_we_i ? (32'd1 << commit_waddr_i) : 32'd0;
    assign issue_bits = issue ? (32'h0000_00FF << {sel_q, 3'b000}) : 32'd0;
    assign load_val   = req_mask_i & ~commit_hit;
    assign run_next   = pending_q & ~commit_hit & ~issue_bits;

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE) && !flush_i && !rst_i;

    // Regfile-side mux: commit passthrough first, then a clear issue, else quiet.
    always_comb begin
        we_o      = 1'b0;
        waddr_o   = 5'd0;
        wdata_o   = '0;
        clr_o     = 1'b0;
        mask_o    = 8'd0;
        quarter_o = 2'd0;
        if (commit_we_i) begin
            we_o    = 1'b1;
            waddr_o = commit_waddr_i;
            wdata_o = commit_wdata_i;
        end else if (issue) begin
            we_o      = 1'b1;
            clr_o     = 1'b1;
            quarter_o = sel_q;
            mask_o    = sel_byte;
            waddr_o   = {sel_q, lsb_idx};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pending_q <= 32'd0;
            qcnt_q    <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        pending_q <= load_val;
                        qcnt_q    <= 2'd0;
                        // A request fully retired by a same-cycle commit has nothing to do.
                        state_q   <= (load_val != 32'd0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (flush_i) begin
                        state_q   <= IDLE;
                        pending_q <= 32'd0;
                        qcnt_q    <= 2'd0;
                    end else begin
                        pending_q <= run_next;
                        // The quarter counter steps on issues and bubbles, not on commit stalls.
                        if (!commit_we_i) qcnt_q <= qcnt_q + 2'd1;
                        if (run_next == 32'd0) state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    pending_q <= 32'd0;
                    qcnt_q    <= 2'd0;
                end
                default: begin
                    state_q   <= IDLE;
                    pending_q <= 32'd0;
                    qcnt_q    <= 2'd0;
                end
            endcase
        end
    end

endmodule
